// File: rtl/elink_tx_packet_writer.sv
// rtl/elink_tx_packet_writer.sv - frames CAN messages into 18-bit elink TX FIFO packets
//
// Purpose: accepts one CAN message per msg_valid/msg_ready handshake and writes
// it to the TX FIFO as SOP, HDR, DATA x ceil(L/2), [CRC], EOP words of the form
// {code[1:0], payload[15:0]}. Codes: 10 SOP, 00 DATA/HDR/CRC, 01 EOP.
//
// Optional feature macro: TX_CRC_EN. When defined, a CRC-16-CCITT word
// (poly 0x1021, init 0xFFFF) over the HDR and DATA payloads precedes EOP.
//
// Ports:
//   clk, rst           write clock, synchronous active-high reset
//   msg_id/len/data    CAN message (byte0 = msg_data[63:56])
//   msg_valid/ready    message handshake
//   fifo_full          FIFO full, stalls the current word
//   fifo_prog_full     FIFO almost full, blocks new packet starts only
//   fifo_flush         aborts the current packet, returns to IDLE
//   fifo_din/wr_en     FIFO write port
//   busy               packet in progress
//   len_err            one-cycle pulse after accepting msg_len > MAX_LEN
//   pkt_cnt            count of packets whose EOP was written (wraps)

module elink_tx_packet_writer #(
    parameter int PKT_CNT_W = 16,
    parameter int MAX_LEN   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [10:0]          msg_id,
    input  logic [3:0]           msg_len,
    input  logic [63:0]          msg_data,
    input  logic                 msg_valid,
    output logic                 msg_ready,
    input  logic                 fifo_full,
    input  logic                 fifo_prog_full,
    input  logic                 fifo_flush,
    output logic [17:0]          fifo_din,
    output logic                 fifo_wr_en,
    output logic                 busy,
    output logic                 len_err,
    output logic [PKT_CNT_W-1:0] pkt_cnt
);

    localparam logic [3:0] MAX_LEN_L = 4'(MAX_LEN);

`ifdef TX_CRC_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_SOP, ST_HDR, ST_DATA, ST_CRC, ST_EOP
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_SOP, ST_HDR, ST_DATA, ST_EOP
    } state_t;
`endif

    state_t               state_q, state_d;
    logic [10:0]          id_q, id_d;
    logic [3:0]           len_q, len_d;
    logic [63:0]          data_q, data_d;
    logic [1:0]           idx_q, idx_d;
    logic                 len_err_q, len_err_d;
    logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

    logic                 accept;
    logic [3:0]           n_words;
    logic                 last_data;
    logic [7:0]           lo_byte;
    state_t               after_payload;

`ifdef TX_CRC_EN
    logic [15:0] crc_q, crc_d;

    function automatic logic [15:0] crc16_upd(input logic [15:0] crc_in,
                                              input logic [15:0] din);
        logic [15:0] c;
        logic        fb;
        c = crc_in;
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ din[i];
            c  = {c[14:0], 1'b0};
            if (fb) begin
                c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction

    assign after_payload = ST_CRC;
`else
    assign after_payload = ST_EOP;
`endif

    // Gated by rst so the port reads 0 while reset is held.
    assign msg_ready  = !rst && (state_q == ST_IDLE) && !fifo_prog_full && !fifo_flush;
    assign accept     = msg_valid && msg_ready;
    assign fifo_wr_en = (state_q != ST_IDLE) && !fifo_full && !fifo_flush;
    assign busy       = (state_q != ST_IDLE);
    assign len_err    = len_err_q;
    assign pkt_cnt    = pkt_cnt_q;

    // Payload bytes shift up through data_q[63:48]; the low byte of the final
    // word is padded when L is odd.
    assign n_words   = (len_q + 4'd1) >> 1;
    assign last_data = ({2'b00, idx_q} == (n_words - 4'd1));
    assign lo_byte   = ({1'b0, idx_q, 1'b1} < len_q) ? data_q[55:48] : 8'h00;

    always_comb begin
        fifo_din = 18'h0;
        case (state_q)
            ST_SOP:  fifo_din = {2'b10, 16'h0000};
            ST_HDR:  fifo_din = {2'b00, 1'b0, len_q, id_q};
            ST_DATA: fifo_din = {2'b00, data_q[63:56], lo_byte};
`ifdef TX_CRC_EN
            ST_CRC:  fifo_din = {2'b00, crc_q};
`endif
            ST_EOP:  fifo_din = {2'b01, 16'h0000};
            default: fifo_din = 18'h0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        len_d     = len_q;
        data_d    = data_q;
        idx_d     = idx_q;
        len_err_d = 1'b0;
        pkt_cnt_d = pkt_cnt_q;
`ifdef TX_CRC_EN
        crc_d     = crc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    id_d      = msg_id;
                    data_d    = msg_data;
                    len_d     = (msg_len > MAX_LEN_L) ? MAX_LEN_L : msg_len;
                    len_err_d = (msg_len > MAX_LEN_L);
                    idx_d     = 2'd0;
`ifdef TX_CRC_EN
                    crc_d     = 16'hFFFF;
`endif
                    state_d   = ST_SOP;
                end
            end
            ST_SOP: begin
                if (fifo_wr_en) begin
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                if (fifo_wr_en) begin
`ifdef TX_CRC_EN
                    crc_d = crc16_upd(crc_q, fifo_din[15:0]);
`endif
                    state_d = (len_q == 4'd0) ? after_payload : ST_DATA;
                end
            end
            ST_DATA: begin
                if (fifo_wr_en) begin
`ifdef TX_CRC_EN
                    crc_d = crc16_upd(crc_q, fifo_din[15:0]);
`endif
                    data_d = {data_q[47:0], 16'h0000};
                    idx_d  = idx_q + 2'd1;
                    if (last_data) begin
                        state_d = after_payload;
                    end
                end
            end
`ifdef TX_CRC_EN
            ST_CRC: begin
                if (fifo_wr_en) begin
                    state_d = ST_EOP;
                end
            end
`endif
            ST_EOP: begin
                if (fifo_wr_en) begin
                    pkt_cnt_d = pkt_cnt_q + PKT_CNT_W'(1);
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Flush abandons whatever was captured; no accept can coincide since
        // msg_ready is low while flush is high.
        if (fifo_flush) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            id_q      <= '0;
            len_q     <= '0;
            data_q    <= '0;
            idx_q     <= '0;
            len_err_q <= 1'b0;
            pkt_cnt_q <= '0;
`ifdef TX_CRC_EN
            crc_q     <= 16'hFFFF;
`endif
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            len_q     <= len_d;
            data_q    <= data_d;
            idx_q     <= idx_d;
            len_err_q <= len_err_d;
            pkt_cnt_q <= pkt_cnt_d;
`ifdef TX_CRC_EN
            crc_q     <= crc_d;
`endif
        end
    end

endmodule

// File: tb/tb_elink_tx_packet_writer.sv
// tb/tb_elink_tx_packet_writer.sv - scoreboard bench for elink_tx_packet_writer

module tb_elink_tx_packet_writer;

`ifdef TX_CRC_EN
    localparam int CRC_WORDS = 1;
`else
    localparam int CRC_WORDS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] msg_id;
    logic [3:0]  msg_len;
    logic [63:0] msg_data;
    logic        msg_valid;
    logic        msg_ready;
    logic        fifo_full;
    logic        fifo_prog_full;
    logic        fifo_flush;
    logic [17:0] fifo_din;
    logic        fifo_wr_en;
    logic        busy;
    logic        len_err;
    logic [15:0] pkt_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [17:0] exp_q[$];
    int          wr_cnt = 0;
    int          busy_cycles = 0;
    logic [15:0] exp_pkt = 16'd0;

    always #5 clk = ~clk;

    elink_tx_packet_writer #(.PKT_CNT_W(16), .MAX_LEN(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .msg_id        (msg_id),
        .msg_len       (msg_len),
        .msg_data      (msg_data),
        .msg_valid     (msg_valid),
        .msg_ready     (msg_ready),
        .fifo_full     (fifo_full),
        .fifo_prog_full(fifo_prog_full),
        .fifo_flush    (fifo_flush),
        .fifo_din      (fifo_din),
        .fifo_wr_en    (fifo_wr_en),
        .busy          (busy),
        .len_err       (len_err),
        .pkt_cnt       (pkt_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] crc_model(input logic [15:0] c_in, input logic [15:0] w);
        logic [15:0] c;
        c = c_in;
        for (int b = 15; b >= 0; b--) begin
            if (c[15] ^ w[b]) c = (c << 1) ^ 16'h1021;
            else              c = c << 1;
        end
        return c;
    endfunction

    task automatic push_packet(input logic [10:0] id, input logic [3:0] len, input logic [63:0] data);
        logic [3:0]  l;
        logic [17:0] w;
        logic [15:0] crc;
        logic [7:0]  b0, b1;
        l = (len > 4'd8) ? 4'd8 : len;
        exp_q.push_back({2'b10, 16'h0000});
        w = {2'b00, 1'b0, l, id};
        exp_q.push_back(w);
        crc = crc_model(16'hFFFF, w[15:0]);
        for (int k = 0; k < (int'(l) + 1) / 2; k++) begin
            b0 = data[63 - 16*k -: 8];
            b1 = (2*k + 1 < int'(l)) ? data[55 - 16*k -: 8] : 8'h00;
            w  = {2'b00, b0, b1};
            exp_q.push_back(w);
            crc = crc_model(crc, w[15:0]);
        end
        if (CRC_WORDS == 1) exp_q.push_back({2'b00, crc});
        exp_q.push_back({2'b01, 16'h0000});
    endtask

    // Offer a message; on acceptance optionally load its expected words.
    // Returns at posedge(accept)+1.
    task automatic send(input logic [10:0] id, input logic [3:0] len, input logic [63:0] data,
                        input bit full_pkt);
        bit done;
        done      = 1'b0;
        msg_id    = id;
        msg_len   = len;
        msg_data  = data;
        msg_valid = 1'b1;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (msg_ready) begin
                done = 1'b1;
                if (full_pkt) push_packet(id, len, data);
                else          exp_q.push_back({2'b10, 16'h0000});
            end
            @(posedge clk);
            #1;
        end
        msg_valid = 1'b0;
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int t = 0; t < 200 && !idle; t++) begin
            @(negedge clk);
            if (!busy) idle = 1'b1;
        end
        if (!idle) check("idle_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (busy) busy_cycles++;
            if (fifo_wr_en) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    check("extra_write", {14'd0, fifo_din}, 32'h0);
                end else begin
                    check("word", {14'd0, fifo_din}, {14'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        rst = 1'b1; msg_id = '0; msg_len = '0; msg_data = '0; msg_valid = 1'b0;
        fifo_full = 1'b0; fifo_prog_full = 1'b0; fifo_flush = 1'b0;
        repeat (2) @(posedge clk);
        msg_valid = 1'b1;
        @(negedge clk);
        check("rst_ready", {31'd0, msg_ready}, 32'd0);
        check("rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
        check("rst_din",   {14'd0, fifo_din}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_len_err", {31'd0, len_err}, 32'd0);
        check("rst_pkt_cnt", {16'd0, pkt_cnt}, 32'd0);
        @(posedge clk); #1;
        msg_valid = 1'b0;
        rst = 1'b0;

        // Full-length message, no stalls.
        busy_cycles = 0; w0 = wr_cnt;
        send(11'h123, 4'd8, 64'h0011223344556677, 1'b1);
        wait_idle();
        exp_pkt++;
        check("t1_writes", wr_cnt - w0, 7 + CRC_WORDS);
        check("t1_busy_cycles", busy_cycles, 7 + CRC_WORDS);
        check("t1_pkt_cnt", {16'd0, pkt_cnt}, {16'd0, exp_pkt});

        // Odd length, padded final byte.
        w0 = wr_cnt;
        send(11'h7FF, 4'd3, 64'hAABBCC00DEADBEEF, 1'b1);
        wait_idle();
        exp_pkt++;
        check("t2_writes", wr_cnt - w0, 5 + CRC_WORDS);

        // Zero length skips DATA.
        w0 = wr_cnt;
        send(11'h000, 4'd0, 64'hFFFFFFFFFFFFFFFF, 1'b1);
        wait_idle();
        exp_pkt++;
        check("t3_writes", wr_cnt - w0, 3 + CRC_WORDS);

        // fifo_full held for 5 cycles after the HDR write.
        busy_cycles = 0; w0 = wr_cnt;
        send(11'h123, 4'd8, 64'h0011223344556677, 1'b1);
        @(posedge clk);           // SOP write
        @(posedge clk); #1;       // HDR write
        fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_wr_en", {31'd0, fifo_wr_en}, 32'd0);
        end
        @(posedge clk); #1;
        fifo_full = 1'b0;
        wait_idle();
        exp_pkt++;
        check("t4_writes", wr_cnt - w0, 7 + CRC_WORDS);
        check("t4_busy_cycles", busy_cycles, 12 + CRC_WORDS);

        // prog_full while idle blocks new packets.
        w0 = wr_cnt;
        fifo_prog_full = 1'b1;
        msg_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("pf_ready", {31'd0, msg_ready}, 32'd0);
        end
        @(posedge clk); #1;
        msg_valid = 1'b0;
        check("pf_no_writes", wr_cnt - w0, 0);
        fifo_prog_full = 1'b0;

        // prog_full rising mid-packet does not stop it.
        w0 = wr_cnt;
        send(11'h2A5, 4'd5, 64'h0102030405060708, 1'b1);
        fifo_prog_full = 1'b1;
        wait_idle();
        exp_pkt++;
        fifo_prog_full = 1'b0;
        check("t5_writes", wr_cnt - w0, 6 + CRC_WORDS);
        check("t5_pkt_cnt", {16'd0, pkt_cnt}, {16'd0, exp_pkt});

        // Flush one cycle after the SOP write.
        w0 = wr_cnt;
        send(11'h111, 4'd8, 64'h1122334455667788, 1'b0);
        @(posedge clk); #1;       // SOP written
        fifo_flush = 1'b1;
        @(negedge clk);
        check("flush_wr_en", {31'd0, fifo_wr_en}, 32'd0);
        @(posedge clk); #1;
        fifo_flush = 1'b0;
        @(negedge clk);
        check("flush_idle", {31'd0, busy}, 32'd0);
        check("flush_writes", wr_cnt - w0, 1);
        check("flush_pkt_cnt", {16'd0, pkt_cnt}, {16'd0, exp_pkt});

        // Flush and valid together in IDLE: flush wins.
        @(posedge clk); #1;
        msg_valid = 1'b1; fifo_flush = 1'b1;
        @(negedge clk);
        check("flush_ready", {31'd0, msg_ready}, 32'd0);
        @(posedge clk); #1;
        msg_valid = 1'b0; fifo_flush = 1'b0;
        @(negedge clk);
        check("flush_no_accept", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;

        // Over-length message is clamped and flagged.
        send(11'h055, 4'hF, 64'hA1A2A3A4A5A6A7A8, 1'b1);
        @(negedge clk);
        check("len_err_pulse", {31'd0, len_err}, 32'd1);
        @(negedge clk);
        check("len_err_clear", {31'd0, len_err}, 32'd0);
        @(posedge clk); #1;
        wait_idle();
        exp_pkt++;
        check("final_pkt_cnt", {16'd0, pkt_cnt}, {16'd0, exp_pkt});
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
